// File: rtl/mont_sub_res_correction.sv
`timescale 1ns/1ps
// mont_sub_res_correction
//   Fix-up stage behind the pipelined Montgomery subtraction multiplier. When
//   the multiplier reports a negative result, this block walks the packed
//   result memory once, adds the prime p digit-serially (ripple carry across
//   entries) and writes every entry back in place. Non-negative results are
//   acknowledged after a single cycle with no memory traffic.
//
//   Entry packing (result and prime memories): entry i = {t[2i], t[2i+1]}, so
//   the upper field holds the less significant digit of the pair.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle request pulse, ignored while busy
//   neg_in            negative-result flag, sampled with an accepted start
//   busy              high from the cycle after start through the done cycle
//   done              one-cycle completion pulse
//   res_rd_en/addr    result memory read port (data on res_dout, 1-cycle latency)
//   res_wr_en/addr    result memory write port, corrected entry on res_din
//   p_rd_en/addr      prime memory read port, mirrors the result read port
//   p_dout            prime read data, 1-cycle latency
//   range_err         (MONT_CORR_CHECK_EN only) set with done when the
//                     negative path ended with final carry 0
//
// Build option
//   MONT_CORR_CHECK_EN  adds the range_err output
module mont_sub_res_correction #(
  parameter int RADIX             = 32,
  parameter int WIDTH_REAL        = 14,
  parameter int WIDTH             = ((WIDTH_REAL + 1) / 2) * 2,
  parameter int RES_MEM_DEPTH     = WIDTH / 2,
  parameter int RES_MEM_DEPTH_LOG = (RES_MEM_DEPTH > 1) ? $clog2(RES_MEM_DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         neg_in,
  output logic                         busy,
  output logic                         done,
`ifdef MONT_CORR_CHECK_EN
  output logic                         range_err,
`endif
  output logic                         res_rd_en,
  output logic [RES_MEM_DEPTH_LOG-1:0] res_rd_addr,
  input  logic [2*RADIX-1:0]           res_dout,
  output logic                         res_wr_en,
  output logic [RES_MEM_DEPTH_LOG-1:0] res_wr_addr,
  output logic [2*RADIX-1:0]           res_din,
  output logic                         p_rd_en,
  output logic [RES_MEM_DEPTH_LOG-1:0] p_rd_addr,
  input  logic [2*RADIX-1:0]           p_dout
);

  localparam logic [RES_MEM_DEPTH_LOG-1:0] LAST_ADDR =
    RES_MEM_DEPTH_LOG'(RES_MEM_DEPTH - 1);
  localparam logic ODD_REAL = (WIDTH_REAL % 2) != 0;

  typedef enum logic [1:0] {IDLE, READ, PASS, DRAIN} state_t;

  state_t                       state, state_d;
  logic [RES_MEM_DEPTH_LOG-1:0] rd_addr;
  logic [1:0]                   drain_cnt;

  // pipeline: v1/a1 = read issued, v2/a2 = operands registered, v3/a3 = sum registered
  logic                         v1, v2, v3;
  logic [RES_MEM_DEPTH_LOG-1:0] a1, a2, a3;
  logic [2*RADIX-1:0]           t_q, p_q, sum_q;
  logic                         carry_q;

  logic                         cin, is_pad, cout;
  logic [RADIX:0]               s0, s1;
  logic [2*RADIX-1:0]           sum_d;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_d;
      rd_addr   <= (state == READ && rd_addr != LAST_ADDR) ?
                   rd_addr + RES_MEM_DEPTH_LOG'(1) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
    end
  end

  // DRAIN spans two wait cycles for the tail of the pipeline plus the done
  // cycle, so busy stays high through done on both paths.
  always_comb begin
    state_d   = state;
    busy      = 1'b0;
    done      = 1'b0;
    res_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = neg_in ? READ : PASS;
      end
      READ: begin
        busy      = 1'b1;
        res_rd_en = 1'b1;
        if (rd_addr == LAST_ADDR) state_d = DRAIN;
      end
      PASS: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd2) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_rd_addr = rd_addr;
  assign p_rd_en     = res_rd_en;
  assign p_rd_addr   = rd_addr;

  // ---------------- add stage ----------------
  // Upper field carries the lower digit, so it is summed first.
  always_comb begin
    cin    = (a2 == '0) ? 1'b0 : carry_q;
    is_pad = ODD_REAL && (a2 == LAST_ADDR);
    s0     = {1'b0, t_q[2*RADIX-1:RADIX]} + {1'b0, p_q[2*RADIX-1:RADIX]} +
             {{RADIX{1'b0}}, cin};
    s1     = {1'b0, t_q[RADIX-1:0]} + {1'b0, p_q[RADIX-1:0]} +
             {{RADIX{1'b0}}, s0[RADIX]};
    sum_d  = {s0[RADIX-1:0], s1[RADIX-1:0]};
    cout   = s1[RADIX];
    if (is_pad) begin
      sum_d = {s0[RADIX-1:0], {RADIX{1'b0}}};
      cout  = s0[RADIX];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      a1      <= '0;
      a2      <= '0;
      a3      <= '0;
      t_q     <= '0;
      p_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      v1 <= res_rd_en;
      a1 <= rd_addr;
      v2 <= v1;
      a2 <= a1;
      v3 <= v2;
      a3 <= a2;
      if (v1) begin
        t_q <= res_dout;
        p_q <= p_dout;
      end
      if (v2) begin
        sum_q   <= sum_d;
        carry_q <= cout;
      end
    end
  end

  assign res_wr_en   = v3;
  assign res_wr_addr = a3;
  assign res_din     = sum_q;

`ifdef MONT_CORR_CHECK_EN
  // Final carry of the last entry lands one cycle ahead of done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (state == IDLE && start) begin
      range_err <= 1'b0;
    end else if (v2 && a2 == LAST_ADDR) begin
      range_err <= ~cout;
    end
  end
`endif

endmodule

// File: tb/tb_mont_sub_res_correction.sv
`timescale 1ns/1ps
module tb_mont_sub_res_correction;
  localparam int D  = 7;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, neg_in, b_start, b_neg_in;
  logic busy, done, res_rd_en, res_wr_en, p_rd_en;
  logic b_busy, b_done, b_res_rd_en, b_res_wr_en, b_p_rd_en;
  logic [AW-1:0] res_rd_addr, res_wr_addr, p_rd_addr;
  logic [AW-1:0] b_res_rd_addr, b_res_wr_addr, b_p_rd_addr;
  logic [63:0] res_dout, res_din, p_dout, b_res_dout, b_res_din, b_p_dout;
`ifdef MONT_CORR_CHECK_EN
  logic range_err, b_range_err;
`endif

  mont_sub_res_correction #(.RADIX(32), .WIDTH_REAL(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .neg_in(neg_in),
    .busy(busy), .done(done),
`ifdef MONT_CORR_CHECK_EN
    .range_err(range_err),
`endif
    .res_rd_en(res_rd_en), .res_rd_addr(res_rd_addr), .res_dout(res_dout),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_din(res_din),
    .p_rd_en(p_rd_en), .p_rd_addr(p_rd_addr), .p_dout(p_dout));

  mont_sub_res_correction #(.RADIX(32), .WIDTH_REAL(13)) dut_odd (
    .clk(clk), .rst_n(rst_n), .start(b_start), .neg_in(b_neg_in),
    .busy(b_busy), .done(b_done),
`ifdef MONT_CORR_CHECK_EN
    .range_err(b_range_err),
`endif
    .res_rd_en(b_res_rd_en), .res_rd_addr(b_res_rd_addr), .res_dout(b_res_dout),
    .res_wr_en(b_res_wr_en), .res_wr_addr(b_res_wr_addr), .res_din(b_res_din),
    .p_rd_en(b_p_rd_en), .p_rd_addr(b_p_rd_addr), .p_dout(b_p_dout));

  // memories with 1-cycle read latency
  logic [63:0] res_mem [D], p_mem [D], res_mem2 [D], p_mem2 [D];
  always @(posedge clk) begin
    if (res_rd_en)   res_dout   <= res_mem[res_rd_addr];
    if (p_rd_en)     p_dout     <= p_mem[p_rd_addr];
    if (res_wr_en)   res_mem[res_wr_addr] <= res_din;
    if (b_res_rd_en) b_res_dout <= res_mem2[b_res_rd_addr];
    if (b_p_rd_en)   b_p_dout   <= p_mem2[b_p_rd_addr];
    if (b_res_wr_en) res_mem2[b_res_wr_addr] <= b_res_din;
  end

  int nchk = 0, npass = 0, nfail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else npass++;
  endtask

  // digit-level reference model
  logic [31:0] pdig [14], tdig [14], edig [14];
  logic        exp_cf;

  task automatic make_t(input int kind, input int nd);
    logic [32:0] acc;
    logic        c;
    for (int unsigned j = 0; j < 14; j++)
      case (kind)
        0:       tdig[j] = '1;
        1:       tdig[j] = pdig[j];
        2:       tdig[j] = (j == 0) ? 32'd5 : 32'd0;
        3:       tdig[j] = (j == 0) ? 32'd1 : 32'd0;
        default: tdig[j] = $urandom;
      endcase
    if (kind == 1 || kind == 2) begin
      c = 1'b1;
      for (int unsigned j = 0; j < nd; j++) begin
        acc     = {1'b0, ~tdig[j]} + {32'd0, c};
        tdig[j] = acc[31:0];
        c       = acc[32];
      end
    end
  endtask

  task automatic model(input int nd, input logic neg);
    logic [32:0] acc;
    logic        c;
    c = 1'b0;
    for (int unsigned j = 0; j < 14; j++) begin
      if (!neg) edig[j] = tdig[j];
      else if (j < nd) begin
        acc     = {1'b0, tdig[j]} + {1'b0, pdig[j]} + {32'd0, c};
        edig[j] = acc[31:0];
        c       = acc[32];
      end else edig[j] = '0;
    end
    exp_cf = c;
  endtask

  typedef struct packed { logic [AW-1:0] a; logic [63:0] d; } wr_t;
  wr_t sb_q [$], sb_q2 [$];
  wr_t e1, e2;
  logic sb_en = 1'b1;
  int wr_cnt = 0, wr_cnt2 = 0, done_cnt = 0, p_mis = 0;

  task automatic load_and_push(input logic sel, input logic neg, input logic [31:0] p_pad);
    for (int unsigned i = 0; i < D; i++) begin
      if (sel) begin
        res_mem2[i] = {tdig[2*i], tdig[2*i+1]};
        p_mem2[i]   = {pdig[2*i], (i == D-1) ? p_pad : pdig[2*i+1]};
        if (neg) sb_q2.push_back({AW'(i), edig[2*i], edig[2*i+1]});
      end else begin
        res_mem[i] = {tdig[2*i], tdig[2*i+1]};
        p_mem[i]   = {pdig[2*i], pdig[2*i+1]};
        if (neg) sb_q.push_back({AW'(i), edig[2*i], edig[2*i+1]});
      end
    end
  endtask

  // write-stream scoreboards
  always @(negedge clk) begin
    if (res_wr_en) begin
      wr_cnt++;
      if (sb_en) begin
        if (sb_q.size() == 0) chk("wr_unexpected", 64'(res_wr_en), 64'd0);
        else begin
          e1 = sb_q.pop_front();
          chk("wr_addr", 64'(res_wr_addr), 64'(e1.a));
          chk("wr_data", res_din, e1.d);
        end
      end
    end
    if (b_res_wr_en) begin
      wr_cnt2++;
      if (sb_q2.size() == 0) chk("odd_wr_unexpected", 64'(b_res_wr_en), 64'd0);
      else begin
        e2 = sb_q2.pop_front();
        chk("odd_wr_addr", 64'(b_res_wr_addr), 64'(e2.a));
        chk("odd_wr_data", b_res_din, e2.d);
      end
    end
    if (done) done_cnt++;
    if (p_rd_en !== res_rd_en || p_rd_addr !== res_rd_addr) p_mis++;
  end

  task automatic run_op(input logic sel, input logic neg, input logic repulse,
                        output int lat, output logic rerr);
    lat  = 0;
    rerr = 1'b0;
    @(negedge clk);
    if (sel) begin b_start = 1'b1; b_neg_in = neg; end
    else     begin start   = 1'b1; neg_in   = neg; end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      b_start = 1'b0;
      if ((sel ? b_done : done) === 1'b1) begin
        lat = n;
`ifdef MONT_CORR_CHECK_EN
        rerr = sel ? b_range_err : range_err;
`endif
        break;
      end
      if (!sel && repulse && n == 3) begin start = 1'b1; neg_in = ~neg; end
    end
    start   = 1'b0;
    b_start = 1'b0;
  endtask

  typedef struct {
    logic neg; int kind; logic repulse; int exp_lat; int exp_nwr;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int   lat;
    logic rerr, found, busy_seen;
    vecs[0] = '{1'b0, 4, 1'b0, 1,  0};   // pass path, random data
    vecs[1] = '{1'b1, 0, 1'b0, 10, 7};   // -1
    vecs[2] = '{1'b1, 1, 1'b0, 10, 7};   // -p
    vecs[3] = '{1'b1, 0, 1'b1, 10, 7};   // -1 with stray start mid-READ
    vecs[4] = '{1'b1, 2, 1'b0, 10, 7};   // -5
    vecs[5] = '{1'b1, 3, 1'b0, 10, 7};   // +1 flagged negative
    vecs[6] = '{1'b0, 0, 1'b0, 1,  0};   // pass path, all ones
    vecs[7] = '{1'b1, 4, 1'b0, 10, 7};   // random
    pdig = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hE2FFFFFF, 32'hFDC1767A,
             32'h3158AEA3, 32'h7BC65C78, 32'h81C52056, 32'h6CFC5FD6,
             32'h27177344, 32'h0002341F};

    rst_n = 1'b0; start = 1'b0; neg_in = 1'b0; b_start = 1'b0; b_neg_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({busy, done, res_rd_en, res_wr_en, p_rd_en,
                          res_rd_addr, res_wr_addr, p_rd_addr}), 64'd0);
    chk("reset_din", res_din, 64'd0);
    rst_n = 1'b1;

    // reset in the middle of READ
    sb_en = 1'b0;
    make_t(0, 14);
    model(14, 1'b1);
    load_and_push(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    start = 1'b1; neg_in = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_rd_en && res_rd_addr == 3'd3) found = 1'b1;
    end
    chk("rst_reach_entry3", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outputs", 64'({busy, done, res_rd_en, res_wr_en, res_wr_addr}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; wr_cnt = 0; done_cnt = 0; busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    chk("rst_no_write", 64'(wr_cnt), 64'd0);
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    chk("rst_not_busy", 64'(busy_seen), 64'd0);
    sb_en = 1'b1;

    foreach (vecs[v]) begin
      make_t(vecs[v].kind, 14);
      model(14, vecs[v].neg);
      load_and_push(1'b0, vecs[v].neg, 32'd0);
      wr_cnt = 0; done_cnt = 0;
      run_op(1'b0, vecs[v].neg, vecs[v].repulse, lat, rerr);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", v), 64'({busy, done}), 64'd0);
      chk($sformatf("v%0d_wr_count", v), 64'(wr_cnt), 64'(vecs[v].exp_nwr));
      chk($sformatf("v%0d_done_count", v), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d_sb_empty", v), 64'(sb_q.size()), 64'd0);
      for (int unsigned i = 0; i < D; i++)
        chk($sformatf("v%0d_mem%0d", v, i), res_mem[i], {edig[2*i], edig[2*i+1]});
`ifdef MONT_CORR_CHECK_EN
      chk($sformatf("v%0d_range_err", v), 64'(rerr), 64'(vecs[v].neg && !exp_cf));
`endif
      sb_q.delete();
    end

    // odd digit count build: -5, pad digit must come back as 0
    make_t(2, 13);
    tdig[13] = 32'hDEADBEEF;
    model(13, 1'b1);
    load_and_push(1'b1, 1'b1, 32'h12345678);
    wr_cnt2 = 0;
    run_op(1'b1, 1'b1, 1'b0, lat, rerr);
    chk("odd_latency", 64'(lat), 64'd10);
    @(negedge clk);
    chk("odd_idle_after", 64'({b_busy, b_done}), 64'd0);
    chk("odd_wr_count", 64'(wr_cnt2), 64'd7);
    chk("odd_sb_empty", 64'(sb_q2.size()), 64'd0);
    for (int unsigned i = 0; i < D; i++)
      chk($sformatf("odd_mem%0d", i), res_mem2[i], {edig[2*i], edig[2*i+1]});
`ifdef MONT_CORR_CHECK_EN
    chk("odd_range_err", 64'(rerr), 64'(!exp_cf));
`endif

    chk("p_rd_tracks_res_rd", 64'(p_mis), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
